// File: rtl/cla64_arbiter.sv
// Two-requester round-robin sequencer sharing one 64-bit carry-lookahead adder.
// Optional signed-overflow output: define CLA_ARB_OVF_EN to add resp_ovf.

// Three-level 4-bit-group carry-lookahead adder with group generate/propagate outputs.
module CLA_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout,
  output logic        gg,
  output logic        gp
);

  function automatic logic [1:0] grp_gp(input logic [3:0] g, input logic [3:0] p);
    logic [1:0] r;
    r[1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    r[0] = &p;
    return r;
  endfunction

  function automatic logic [3:0] grp_carry(input logic [3:0] g, input logic [3:0] p,
                                           input logic c0);
    logic [3:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  logic [63:0] bit_g, bit_p, bit_c;
  logic [15:0] l1_g, l1_p, l1_c;
  logic [3:0]  l2_g, l2_p, l2_c;

  always_comb begin
    // NOTE: every variable gets a default first so no path through this block infers a latch.
    bit_c = '0;
    l1_g  = '0;
    l1_p  = '0;
    l1_c  = '0;
    bit_g = a & b;
    bit_p = a ^ b;

    // Generate/propagate flow upward: bits -> 4-bit groups -> 16-bit blocks -> whole word.
    for (int j = 0; j < 16; j++) begin
      {l1_g[j], l1_p[j]} = grp_gp(bit_g[4*j +: 4], bit_p[4*j +: 4]);
    end
    for (int k = 0; k < 4; k++) begin
      {l2_g[k], l2_p[k]} = grp_gp(l1_g[4*k +: 4], l1_p[4*k +: 4]);
    end
    {gg, gp} = grp_gp(l2_g, l2_p);

    // Carries flow back down from cin without any rippling between groups.
    l2_c = grp_carry(l2_g, l2_p, cin);
    for (int k = 0; k < 4; k++) begin
      l1_c[4*k +: 4] = grp_carry(l1_g[4*k +: 4], l1_p[4*k +: 4], l2_c[k]);
    end
    for (int j = 0; j < 16; j++) begin
      bit_c[4*j +: 4] = grp_carry(bit_g[4*j +: 4], bit_p[4*j +: 4], l1_c[j]);
    end

    sum  = bit_p ^ bit_c;
    cout = gg | (gp & cin);
  end

endmodule

module cla64_arbiter #(
  parameter int MAX_BEATS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_a0,
  input  logic [63:0] req_b0,
  input  logic [63:0] req_a1,
  input  logic [63:0] req_b1,
  input  logic [1:0]  req_sub,
  input  logic [1:0]  req_last,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [63:0] resp_sum,
  output logic        resp_cout,
  output logic        resp_err
`ifdef CLA_ARB_OVF_EN
  ,
  output logic        resp_ovf
`endif
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t      state;
  logic        rr_last;
  logic        sub_q;
  logic        carry_q;
  logic [CW-1:0] beat_cnt;

  logic [1:0]  accept;
  logic        acc_any;
  logic        acc_id;
  logic        first_beat;
  logic        op_sub;
  logic        op_last;
  logic        op_cin;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic [63:0] op_b_eff;
  logic [CW-1:0] cnt_next;
  logic        abort;

  logic [63:0] add_sum;
  logic        add_cout;
  logic        add_gg;
  logic        add_gp;

  // Grant depends only on state, rr_last and valid; operands never reach req_ready.
  always_comb begin
    req_ready = 2'b00;
    if (!rst) begin
      case (state)
        IDLE: begin
          case (req_valid)
            2'b01:   req_ready = 2'b01;
            2'b10:   req_ready = 2'b10;
            2'b11:   req_ready = rr_last ? 2'b01 : 2'b10;
            default: req_ready = 2'b00;
          endcase
        end
        LOCK0:   req_ready = 2'b01;
        LOCK1:   req_ready = 2'b10;
        default: req_ready = 2'b00;
      endcase
    end
  end

  assign accept     = req_valid & req_ready;
  assign acc_any    = |accept;
  assign acc_id     = accept[1];
  assign first_beat = (state == IDLE);

  always_comb begin
    op_a     = acc_id ? req_a1 : req_a0;
    op_b     = acc_id ? req_b1 : req_b0;
    op_last  = req_last[acc_id];
    // The first beat of an operation takes its mode straight from the requester.
    op_sub   = first_beat ? req_sub[acc_id] : sub_q;
    op_cin   = first_beat ? op_sub : carry_q;
    op_b_eff = op_sub ? ~op_b : op_b;
    cnt_next = first_beat ? CW'(1) : beat_cnt + CW'(1);
    abort    = !op_last && (cnt_next == CW'(MAX_BEATS));
  end

  CLA_64bit u_cla (
    .a    (op_a),
    .b    (op_b_eff),
    .cin  (op_cin),
    .sum  (add_sum),
    .cout (add_cout),
    .gg   (add_gg),
    .gp   (add_gp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_last    <= 1'b1;
      sub_q      <= 1'b0;
      carry_q    <= 1'b0;
      beat_cnt   <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_sum   <= '0;
      resp_cout  <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      resp_valid <= acc_any;
      if (acc_any) begin
        resp_id   <= acc_id;
        resp_sum  <= add_sum;
        resp_cout <= add_cout;
        resp_err  <= abort;
        carry_q   <= add_cout;
        beat_cnt  <= cnt_next;
        if (first_beat) begin
          sub_q   <= op_sub;
          rr_last <= acc_id;
          if (!op_last) begin
            state <= acc_id ? LOCK1 : LOCK0;
          end
        end else if (op_last || abort) begin
          state <= IDLE;
        end
      end
    end
  end

`ifdef CLA_ARB_OVF_EN
  // Signed overflow: operands agree in sign but the result does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_ovf <= 1'b0;
    end else if (acc_any) begin
      resp_ovf <= (op_a[63] == op_b_eff[63]) && (add_sum[63] != op_a[63]);
    end
  end
`endif

endmodule

// File: tb/tb_cla64_arbiter.sv
// Self-checking bench for cla64_arbiter: table-driven beats, hand-written corner
// sequences and a random phase, all scored through an expected-response queue.
module tb_cla64_arbiter;

  localparam int MAX_BEATS = 4;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]  req_sub, req_last;
  logic        resp_valid, resp_id, resp_cout, resp_err;
  logic [63:0] resp_sum;
`ifdef CLA_ARB_OVF_EN
  logic        resp_ovf;
`endif

  always #5 clk = ~clk;

  cla64_arbiter #(.MAX_BEATS(MAX_BEATS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .req_sub    (req_sub),
    .req_last   (req_last),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_cout  (resp_cout),
    .resp_err   (resp_err)
`ifdef CLA_ARB_OVF_EN
    ,
    .resp_ovf   (resp_ovf)
`endif
  );

  typedef struct packed {
    logic        id;
    logic [63:0] sum;
    logic        cout;
    logic        err;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic        id;
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic        last;
    exp_t        exp;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t held;

  // Reference model state: -1 idle, otherwise the locked requester.
  int   m_lock;
  logic m_rr, m_carry, m_sub;
  int   m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lock  = -1;
    m_rr    = 1'b1;
    m_carry = 1'b0;
    m_sub   = 1'b0;
    m_cnt   = 0;
    held    = '0;
    sb.delete();
  endtask

  function automatic logic [1:0] model_ready();
    if (rst) return 2'b00;
    if (m_lock == 0) return 2'b01;
    if (m_lock == 1) return 2'b10;
    case (req_valid)
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      2'b11:   return m_rr ? 2'b01 : 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_accept(input logic id, output exp_t m);
    logic [63:0] a, b, bb;
    logic        first, sub, cin, err;
    logic [64:0] r;
    int          cnt;
    a     = id ? req_a1 : req_a0;
    b     = id ? req_b1 : req_b0;
    first = (m_lock < 0);
    sub   = first ? req_sub[id] : m_sub;
    bb    = sub ? ~b : b;
    cin   = first ? sub : m_carry;
    r     = {1'b0, a} + {1'b0, bb} + {64'd0, cin};
    cnt   = first ? 1 : m_cnt + 1;
    err   = !req_last[id] && (cnt == MAX_BEATS);
    m.id   = id;
    m.sum  = r[63:0];
    m.cout = r[64];
    m.err  = err;
    m.ovf  = (a[63] == bb[63]) && (r[63] != a[63]);
    m_carry = r[64];
    m_cnt   = cnt;
    if (first) begin
      m_sub = sub;
      m_rr  = id;
      if (!req_last[id]) m_lock = int'(id);
    end else if (req_last[id] || err) begin
      m_lock = -1;
    end
  endtask

  task automatic check_resp();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("resp_valid", 64'(resp_valid), 64'd1);
      check("resp_id",    64'(resp_id),    64'(e.id));
      check("resp_sum",   resp_sum,        e.sum);
      check("resp_cout",  64'(resp_cout),  64'(e.cout));
      check("resp_err",   64'(resp_err),   64'(e.err));
`ifdef CLA_ARB_OVF_EN
      check("resp_ovf",   64'(resp_ovf),   64'(e.ovf));
`endif
      held = e;
    end else begin
      check("resp_valid idle", 64'(resp_valid), 64'd0);
      check("resp_sum hold",   resp_sum,        held.sum);
    end
  endtask

  // One clock: check grant, score any accept, then check the registered response.
  task automatic step(input logic use_exp, input exp_t e, output logic [1:0] acc);
    logic [1:0] rdy;
    exp_t       m;
    #1;
    rdy = model_ready();
    check("req_ready", 64'(req_ready), 64'(rdy));
    acc = req_valid & rdy;
    if (|acc) begin
      model_accept(acc[1], m);
      sb.push_back(use_exp ? e : m);
    end
    @(negedge clk);
    check_resp();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst req_ready",  64'(req_ready),  64'd0);
    check("rst resp_valid", 64'(resp_valid), 64'd0);
    check("rst resp_id",    64'(resp_id),    64'd0);
    check("rst resp_sum",   resp_sum,        64'd0);
    check("rst resp_cout",  64'(resp_cout),  64'd0);
    check("rst resp_err",   64'(resp_err),   64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_req(input logic id, input logic [63:0] a, input logic [63:0] b,
                         input logic sub, input logic last);
    if (id) begin
      req_a1 = a; req_b1 = b;
    end else begin
      req_a0 = a; req_b0 = b;
    end
    req_sub[id]  = sub;
    req_last[id] = last;
  endtask

  function automatic exp_t mk(input logic id, input logic [63:0] sum, input logic cout,
                              input logic err, input logic ovf);
    exp_t e;
    e.id = id; e.sum = sum; e.cout = cout; e.err = err; e.ovf = ovf;
    return e;
  endfunction

  vec_t       vecs[10];
  logic [1:0] acc;
  logic [1:0] hold;

  initial begin
    rst       = 1'b1;
    req_valid = 2'b00;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    req_sub   = 2'b00;
    req_last  = 2'b00;
    model_reset();

    vecs[0] = '{1'b0, ONES, 64'd1, 1'b0, 1'b1, mk(1'b0, 64'd0, 1'b1, 1'b0, 1'b0)};
    vecs[1] = '{1'b1, ONES, 64'd1, 1'b0, 1'b0, mk(1'b1, 64'd0, 1'b1, 1'b0, 1'b0)};
    vecs[2] = '{1'b1, 64'd0, 64'd0, 1'b0, 1'b1, mk(1'b1, 64'd1, 1'b0, 1'b0, 1'b0)};
    vecs[3] = '{1'b0, 64'd5, 64'd7, 1'b1, 1'b1,
                mk(1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0)};
    vecs[4] = '{1'b0, MSB, 64'd1, 1'b1, 1'b1,
                mk(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1)};
    // 128-bit subtract {1,0} - {0,1}; req_sub on the second beat must be ignored.
    vecs[5] = '{1'b1, 64'd0, 64'd1, 1'b1, 1'b0, mk(1'b1, ONES, 1'b0, 1'b0, 1'b0)};
    vecs[6] = '{1'b1, 64'd1, 64'd0, 1'b0, 1'b1, mk(1'b1, 64'd0, 1'b1, 1'b0, 1'b0)};
    vecs[7] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1,
                mk(1'b0, MSB, 1'b0, 1'b0, 1'b1)};
    vecs[8] = '{1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b1,
                mk(1'b0, ONES, 1'b0, 1'b0, 1'b0)};
    vecs[9] = '{1'b1, MSB, MSB, 1'b0, 1'b1, mk(1'b1, 64'd0, 1'b1, 1'b0, 1'b1)};

    @(negedge clk);
    req_valid = 2'b11;
    do_reset();

    // Table: one requester at a time, back-to-back beats.
    for (int i = 0; i < 10; i++) begin
      req_valid = 2'b00;
      req_valid[vecs[i].id] = 1'b1;
      set_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].last);
      step(1'b1, vecs[i].exp, acc);
    end

    // Requester 1 chain locks out a waiting requester 0.
    req_valid = 2'b01;
    set_req(1'b0, 64'd3, 64'd4, 1'b0, 1'b1);
    step(1'b1, mk(1'b0, 64'd7, 1'b0, 1'b0, 1'b0), acc);
    set_req(1'b0, 64'd10, 64'd20, 1'b0, 1'b1);
    set_req(1'b1, ONES, 64'd1, 1'b0, 1'b0);
    req_valid = 2'b11;
    step(1'b1, mk(1'b1, 64'd0, 1'b1, 1'b0, 1'b0), acc);
    set_req(1'b1, 64'd0, 64'd0, 1'b0, 1'b1);
    step(1'b1, mk(1'b1, 64'd1, 1'b0, 1'b0, 1'b0), acc);
    req_valid = 2'b01;
    step(1'b1, mk(1'b0, 64'd30, 1'b0, 1'b0, 1'b0), acc);

    // Fairness after reset: both always valid, single-beat operations alternate 0,1,0,1.
    req_valid = 2'b00;
    do_reset();
    set_req(1'b0, 64'd1, 64'd1, 1'b0, 1'b1);
    set_req(1'b1, 64'd2, 64'd2, 1'b0, 1'b1);
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, mk(1'(k % 2), (k % 2) ? 64'd4 : 64'd2, 1'b0, 1'b0, 1'b0), acc);
      check("fair grant", 64'(acc), (k % 2) ? 64'd2 : 64'd1);
    end

    // Abort: requester 0 issues MAX_BEATS beats without last; requester 1 waits.
    set_req(1'b0, ONES, 64'd1, 1'b0, 1'b0);
    step(1'b1, mk(1'b0, 64'd0, 1'b1, 1'b0, 1'b0), acc);
    set_req(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    step(1'b1, mk(1'b0, 64'd1, 1'b0, 1'b0, 1'b0), acc);
    step(1'b1, mk(1'b0, 64'd0, 1'b0, 1'b0, 1'b0), acc);
    step(1'b1, mk(1'b0, 64'd0, 1'b0, 1'b1, 1'b0), acc);
    step(1'b1, mk(1'b1, 64'd4, 1'b0, 1'b0, 1'b0), acc);
    check("post-abort grant", 64'(acc), 64'd2);

    // Reset in the middle of a chain that has a pending carry.
    set_req(1'b0, ONES, 64'd1, 1'b0, 1'b0);
    step(1'b1, mk(1'b0, 64'd0, 1'b1, 1'b0, 1'b0), acc);
    do_reset();
    set_req(1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    step(1'b1, mk(1'b0, 64'd0, 1'b0, 1'b0, 1'b0), acc);
    req_valid = 2'b10;
    step(1'b1, mk(1'b1, 64'd4, 1'b0, 1'b0, 1'b0), acc);

    // Random traffic; data and valid are held stable until accepted.
    hold = 2'b00;
    for (int c = 0; c < 80; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!hold[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          set_req(1'(i),
                  ($urandom_range(0, 4) == 0) ? ONES : {$urandom(), $urandom()},
                  ($urandom_range(0, 4) == 0) ? 64'd1 : {$urandom(), $urandom()},
                  1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
        end
      end
      step(1'b0, '0, acc);
      hold = req_valid & ~acc;
    end

    req_valid = 2'b00;
    step(1'b0, '0, acc);
    check("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
